// File: rtl/rob_bp.sv
// Reorder buffer: tags read requests, forwards them to memory under backpressure,
// absorbs out-of-order memory responses by tag and retires them strictly in order.
module rob_bp #(
  parameter int ROB_SIZE = 16,
  parameter int SWIDTH   = 4,
  parameter int AWIDTH   = 32,
  parameter int DWIDTH   = 32,
  parameter int PWIDTH   = 10,
  parameter int IDWIDTH  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_val,
  output logic               req_ready,
  input  logic [AWIDTH-1:0]  req_addr,
  input  logic [IDWIDTH-1:0] req_ID,
  input  logic [PWIDTH-1:0]  req_param,
  output logic               rsp_val,
  input  logic               rsp_ready,
  output logic [DWIDTH-1:0]  rsp_data,
  output logic [IDWIDTH-1:0] rsp_ID,
  output logic [PWIDTH-1:0]  rsp_param,
  output logic               rsp_err,
  output logic               mem_req_val,
  input  logic               mem_req_ready,
  output logic [AWIDTH-1:0]  mem_req_addr,
  output logic [SWIDTH-1:0]  mem_req_ID,
  input  logic               mem_rsp_val,
  input  logic [SWIDTH-1:0]  mem_rsp_ID,
  input  logic [DWIDTH-1:0]  mem_rsp_data,
  input  logic               mem_rsp_err,
  output logic [SWIDTH:0]    occupancy,
  output logic               spurious_err
);

  typedef enum logic [1:0] {S_FREE, S_PEND, S_DONE} slot_st_e;
  typedef struct packed {
    logic [IDWIDTH-1:0] id;
    logic [PWIDTH-1:0]  param;
  } req_meta_t;
  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic              err;
  } mem_res_t;

  localparam logic [SWIDTH-1:0] LAST = SWIDTH'(ROB_SIZE - 1);
  localparam logic [SWIDTH:0]   FULL = ROB_SIZE[SWIDTH:0];

  slot_st_e          st   [ROB_SIZE];
  req_meta_t         meta [ROB_SIZE];
  mem_res_t          res  [ROB_SIZE];
  logic [SWIDTH-1:0] put, head;
  logic              req_beat, rsp_hit, retire, tag_in_range;

  assign req_ready    = (occupancy != FULL) && (!mem_req_val || mem_req_ready);
  assign req_beat     = req_val && req_ready;
  assign tag_in_range = 32'(mem_rsp_ID) < ROB_SIZE;
  assign rsp_hit      = mem_rsp_val && tag_in_range && (st[mem_rsp_ID] == S_PEND);
  // Head state is the registered view, so a same-cycle response to the head waits a cycle.
  assign retire       = (st[head] == S_DONE) && (!rsp_val || rsp_ready);

  // Write order matters: an alloc landing on the slot being retired must win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ROB_SIZE; i++) st[i] <= S_FREE;
      put          <= '0;
      head         <= '0;
      occupancy    <= '0;
      spurious_err <= 1'b0;
    end else begin
      if (retire) begin
        st[head] <= S_FREE;
        head     <= (head == LAST) ? '0 : head + SWIDTH'(1);
      end
      if (rsp_hit) st[mem_rsp_ID] <= S_DONE;
      if (req_beat) begin
        st[put] <= S_PEND;
        put     <= (put == LAST) ? '0 : put + SWIDTH'(1);
      end
      if (mem_rsp_val && !rsp_hit) spurious_err <= 1'b1;
      unique case ({req_beat, retire})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (req_beat) meta[put] <= '{id: req_ID, param: req_param};
    if (rsp_hit)  res[mem_rsp_ID] <= '{data: mem_rsp_data, err: mem_rsp_err};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_val  <= 1'b0;
      mem_req_addr <= '0;
      mem_req_ID   <= '0;
    end else if (req_beat) begin
      mem_req_val  <= 1'b1;
      mem_req_addr <= req_addr;
      mem_req_ID   <= put;
    end else if (mem_req_ready) begin
      mem_req_val  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_val   <= 1'b0;
      rsp_data  <= '0;
      rsp_ID    <= '0;
      rsp_param <= '0;
      rsp_err   <= 1'b0;
    end else if (retire) begin
      rsp_val   <= 1'b1;
      rsp_data  <= res[head].data;
      rsp_err   <= res[head].err;
      rsp_ID    <= meta[head].id;
      rsp_param <= meta[head].param;
    end else if (rsp_ready) begin
      rsp_val   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rob_bp.sv
// Scoreboard bench for rob_bp: request order and memory-request order are queued at
// issue time and checked when the DUT hands the beats out.
module tb_rob_bp;
  localparam int RS = 5, SW = 3, AW = 32, DW = 32, PW = 10, IW = 16;

  logic          clk, rst;
  logic          req_val, req_ready, rsp_val, rsp_ready, rsp_err;
  logic [AW-1:0] req_addr, mem_req_addr;
  logic [IW-1:0] req_ID, rsp_ID;
  logic [PW-1:0] req_param, rsp_param;
  logic [DW-1:0] rsp_data, mem_rsp_data;
  logic          mem_req_val, mem_req_ready, mem_rsp_val, mem_rsp_err, spurious_err;
  logic [SW-1:0] mem_req_ID, mem_rsp_ID;
  logic [SW:0]   occupancy;

  rob_bp #(.ROB_SIZE(RS), .SWIDTH(SW), .AWIDTH(AW), .DWIDTH(DW), .PWIDTH(PW), .IDWIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_ready(req_ready), .req_addr(req_addr), .req_ID(req_ID),
    .req_param(req_param),
    .rsp_val(rsp_val), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ID(rsp_ID),
    .rsp_param(rsp_param), .rsp_err(rsp_err),
    .mem_req_val(mem_req_val), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_ID(mem_req_ID),
    .mem_rsp_val(mem_rsp_val), .mem_rsp_ID(mem_rsp_ID), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_err(mem_rsp_err),
    .occupancy(occupancy), .spurious_err(spurious_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] id; logic [PW-1:0] param; int seq; } exp_t;
  typedef struct { int tag; logic [AW-1:0] addr; } mexp_t;

  exp_t          rq[$];
  mexp_t         mq[$];
  exp_t          re;
  mexp_t         me;
  logic [DW-1:0] d_by_seq [256];
  logic          e_by_seq [256];
  int            slot_seq [RS];
  bit            pend_m   [RS];
  int            put_m, seq_cnt;
  bit            sp_m;
  int            ncheck, npass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncheck++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Output monitors sample mid-cycle; a sampled handshake completes on the next rising edge.
  always @(negedge clk) if (!rst) begin
    if (rsp_val && rsp_ready) begin
      if (rq.size() == 0) chk("rsp_extra", 1, 0);
      else begin
        re = rq.pop_front();
        chk("rsp_id",    rsp_ID,    re.id);
        chk("rsp_param", rsp_param, re.param);
        chk("rsp_data",  rsp_data,  d_by_seq[re.seq]);
        chk("rsp_err",   rsp_err,   e_by_seq[re.seq]);
      end
    end
    if (mem_req_val && mem_req_ready) begin
      if (mq.size() == 0) chk("memreq_extra", 1, 0);
      else begin
        me = mq.pop_front();
        chk("memreq_id",   mem_req_ID,   me.tag);
        chk("memreq_addr", mem_req_addr, me.addr);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rq.delete(); mq.delete();
    for (int i = 0; i < RS; i++) pend_m[i] = 1'b0;
    put_m = 0; sp_m = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_occ",     occupancy,    0);
    chk("rst_rspval",  rsp_val,      0);
    chk("rst_memval",  mem_req_val,  0);
    chk("rst_spur",    spurious_err, 0);
    chk("rst_reqrdy",  req_ready,    1);
  endtask

  task automatic do_req(input logic [IW-1:0] id, input logic [PW-1:0] prm, input logic [AW-1:0] addr);
    exp_t  e;
    mexp_t m;
    int    n;
    n = 0;
    req_val = 1'b1; req_ID = id; req_param = prm; req_addr = addr;
    #1;
    while (!req_ready && n < 40) begin tick(); n++; end
    if (!req_ready) begin
      chk("req_timeout", 0, 1);
      req_val = 1'b0;
      return;
    end
    e.id = id; e.param = prm; e.seq = seq_cnt;
    m.tag = put_m; m.addr = addr;
    rq.push_back(e); mq.push_back(m);
    slot_seq[put_m] = seq_cnt;
    pend_m[put_m] = 1'b1;
    put_m = (put_m + 1) % RS;
    seq_cnt = (seq_cnt + 1) % 256;
    tick();
    req_val = 1'b0;
  endtask

  task automatic mem_rsp(input int tag, input logic [DW-1:0] d, input logic e);
    bit hit;
    hit = 1'b0;
    if (tag < RS) hit = pend_m[tag];
    mem_rsp_val = 1'b1; mem_rsp_ID = SW'(tag); mem_rsp_data = d; mem_rsp_err = e;
    if (hit) begin
      d_by_seq[slot_seq[tag]] = d;
      e_by_seq[slot_seq[tag]] = e;
      pend_m[tag] = 1'b0;
    end else sp_m = 1'b1;
    tick();
    mem_rsp_val = 1'b0;
    chk("spurious", spurious_err, sp_m);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (rq.size() != 0 && n < 60) begin tick(); n++; end
    chk("drain_left", rq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ncheck = 0; npass = 0; seq_cnt = 0; put_m = 0; sp_m = 1'b0;
    rst = 1'b1; req_val = 1'b0; req_addr = '0; req_ID = '0; req_param = '0;
    rsp_ready = 1'b1; mem_req_ready = 1'b1;
    mem_rsp_val = 1'b0; mem_rsp_ID = '0; mem_rsp_data = '0; mem_rsp_err = 1'b0;

    // in-order responses, one-cycle retire latency
    do_reset();
    for (int i = 0; i < 4; i++) do_req(IW'(i + 1), PW'(16 + i), AW'(32'h1000 + i * 4));
    for (int t = 0; t < 4; t++) begin
      mem_rsp(t, DW'(32'hA000 + t), 1'b0);
      chk("t1_lat0", rsp_val, 0);
      tick();
      chk("t1_lat1", rsp_val, 1);
    end
    drain();
    chk("t1_occ", occupancy, 0);

    // reverse-order responses release everything back to back
    do_reset();
    for (int i = 0; i < 4; i++) do_req(IW'(32'h20 + i), PW'(i), AW'(32'h2000 + i * 4));
    for (int t = 3; t > 0; t--) begin
      mem_rsp(t, DW'(32'hB000 + t), 1'b0);
      tick();
      chk("t2_hold", rsp_val, 0);
    end
    mem_rsp(0, DW'(32'hB000), 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_b2b", rsp_val, 1);
    end
    tick();
    chk("t2_end", rsp_val, 0);
    chk("t2_left", rq.size(), 0);
    chk("t2_occ", occupancy, 0);

    // full buffer, then wrap onto tag 0
    do_reset();
    for (int i = 0; i < RS; i++) do_req(IW'(32'h30 + i), PW'(i), AW'(32'h3000 + i * 4));
    chk("t3_full_rdy", req_ready, 0);
    chk("t3_full_occ", occupancy, RS);
    tick();
    chk("t3_full_rdy2", req_ready, 0);
    mem_rsp(0, DW'(32'hC000), 1'b0);
    tick();
    chk("t3_occ_ret", occupancy, RS - 1);
    do_req(IW'(32'h66), PW'(9), AW'(32'h3FF0));
    chk("t3_occ_refill", occupancy, RS);
    for (int t = 1; t < RS; t++) mem_rsp(t, DW'(32'hC000 + t), 1'b0);
    mem_rsp(0, DW'(32'hC0FF), 1'b0);
    drain();
    chk("t3_occ", occupancy, 0);

    // memory-request and response backpressure
    do_reset();
    mem_req_ready = 1'b0;
    do_req(IW'(7), PW'(1), AW'(32'hBEEF0000));
    for (int i = 0; i < 3; i++) begin
      chk("t4_reqrdy", req_ready, 0);
      chk("t4_maddr", mem_req_addr, 32'hBEEF0000);
      chk("t4_mid", mem_req_ID, 0);
      tick();
    end
    mem_req_ready = 1'b1;
    do_req(IW'(8), PW'(2), AW'(32'hBEEF0004));
    rsp_ready = 1'b0;
    mem_rsp(0, DW'(32'hD0), 1'b0);
    mem_rsp(1, DW'(32'hD1), 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_rspval", rsp_val, 1);
      chk("t4_rspid", rsp_ID, 7);
      chk("t4_rspdata", rsp_data, 32'hD0);
    end
    rsp_ready = 1'b1;
    drain();

    // error bit per entry, out-of-range tag flagged without disturbing order
    do_reset();
    for (int i = 0; i < 4; i++) do_req(IW'(32'h50 + i), PW'(i), AW'(32'h5000 + i * 4));
    mem_rsp(1, DW'(32'hE1), 1'b0);
    mem_rsp(7, DW'(32'hBAD), 1'b0);
    mem_rsp(2, DW'(32'hE2), 1'b1);
    mem_rsp(0, DW'(32'hE0), 1'b0);
    mem_rsp(3, DW'(32'hE3), 1'b0);
    drain();

    // repeat response to a DONE slot must not overwrite it; FREE slot also spurious
    do_reset();
    rsp_ready = 1'b0;
    do_req(IW'(32'h60), PW'(0), AW'(32'h6000));
    do_req(IW'(32'h61), PW'(1), AW'(32'h6004));
    mem_rsp(0, DW'(32'hF0), 1'b0);
    mem_rsp(1, DW'(32'hF1), 1'b0);
    mem_rsp(1, DW'(32'hFFFF), 1'b1);
    mem_rsp(4, DW'(32'h44), 1'b0);
    rsp_ready = 1'b1;
    drain();

    // reset with entries pending; a late response is then spurious
    do_reset();
    for (int i = 0; i < 3; i++) do_req(IW'(32'h70 + i), PW'(i), AW'(32'h7000 + i * 4));
    chk("t6_occ_pre", occupancy, 3);
    do_reset();
    mem_rsp(1, DW'(32'h71), 1'b0);
    tick();
    chk("t6_rspval", rsp_val, 0);
    chk("t6_occ", occupancy, 0);

    $display("%0d/%0d checks passed", npass, ncheck);
    $finish;
  end
endmodule
